immediate_encoder: RTL and testbench

- Packs a 32-bit immediate value into the correct RV32I instruction fields for a given immediate format (I/S/B/U/J).
- Merges the packed fields with a caller-supplied base instruction and returns the encoded word through a valid/ready stream.
- Includes a 2-entry output buffer and optional range checking.
- Sits in the debug/instruction-injection path. It is the inverse of the core's immediate decode, so any encoded word must decode back to the original immediate.

---
 rtl/immediate_encoder.sv | 135 +++++++++++++
 tb/tb_immediate_encoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_encoder.sv
// rtl/immediate_encoder.sv - RV32I immediate field packer with 2-entry output FIFO; optional range check under IMM_RANGE_CHECK_EN

`ifndef IMMG_OP_BUS
`define IMMG_OP_BUS 2:0
`endif
`ifndef REG_BUS
`define REG_BUS 31:0
`endif
`ifndef INSTR_BUS
`define INSTR_BUS 31:0
`endif
`ifndef IMMG_OP_I
`define IMMG_OP_I 3'd0
`endif
`ifndef IMMG_OP_S
`define IMMG_OP_S 3'd1
`endif
`ifndef IMMG_OP_B
`define IMMG_OP_B 3'd2
`endif
`ifndef IMMG_OP_U
`define IMMG_OP_U 3'd3
`endif
`ifndef IMMG_OP_J
`define IMMG_OP_J 3'd4
`endif

module immediate_encoder #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [`IMMG_OP_BUS]  in_immg_op,
   input  logic [`REG_BUS]      in_imm,
   input  logic [`INSTR_BUS]    in_base,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [`INSTR_BUS]    out_instr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   // Each FIFO entry is {instr, err}
   logic [32:0]          ent_q [0:1];
   logic [32:0]          ent_d [0:1];
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [1:0]           count_q, count_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

   logic [31:0] enc_instr;
   logic        enc_err;
   logic        push;
   logic        pop;
   logic [32:0] head;

   // Pack immediate bits into the format's fields; everything else comes from the base word
   always_comb begin
      enc_instr = in_base;
      enc_err   = 1'b0;
      case (in_immg_op)
         `IMMG_OP_I: enc_instr = {in_imm[11:0], in_base[19:0]};
         `IMMG_OP_S: enc_instr = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
         `IMMG_OP_B: enc_instr = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1],
                                  in_imm[11], in_base[6:0]};
         `IMMG_OP_U: enc_instr = {in_imm[31:12], in_base[11:0]};
         `IMMG_OP_J: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                  in_base[11:0]};
         default:    enc_err   = 1'b1;
      endcase
`ifdef IMM_RANGE_CHECK_EN
      // Flag immediates the format cannot represent; packed bits stay truncated
      case (in_immg_op)
         `IMMG_OP_I, `IMMG_OP_S:
            if (in_imm != {{20{in_imm[11]}}, in_imm[11:0]}) enc_err = 1'b1;
         `IMMG_OP_B:
            if ((in_imm != {{19{in_imm[12]}}, in_imm[12:0]}) || in_imm[0]) enc_err = 1'b1;
         `IMMG_OP_U:
            if (in_imm[11:0] != 12'd0) enc_err = 1'b1;
         `IMMG_OP_J:
            if ((in_imm != {{11{in_imm[20]}}, in_imm[20:0]}) || in_imm[0]) enc_err = 1'b1;
         default: ;
      endcase
`endif
   end

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = ent_q[rd_ptr_q];
   assign out_instr = out_valid ? head[32:1] : 32'd0;
   assign out_err   = out_valid ? head[0] : 1'b0;
   assign err_count = err_count_q;

   // FIFO pointer/occupancy bookkeeping and saturating error count
   always_comb begin
      ent_d[0]    = ent_q[0];
      ent_d[1]    = ent_q[1];
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      err_count_d = err_count_q;
      if (push) begin
         ent_d[wr_ptr_q] = {enc_instr, enc_err};
         wr_ptr_d        = ~wr_ptr_q;
         if (enc_err && (err_count_q != {ERR_CNT_W{1'b1}}))
            err_count_d = err_count_q + 1'b1;
      end
      if (pop)
         rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   // State registers; reset empties the FIFO immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q[0]    <= '0;
         ent_q[1]    <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         err_count_q <= '0;
      end else begin
         ent_q[0]    <= ent_d[0];
         ent_q[1]    <= ent_d[1];
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_immediate_encoder.sv
// tb/tb_immediate_encoder.sv - self-checking bench for immediate_encoder

module tb_immediate_encoder;

   localparam int ERR_CNT_W = 8;
   localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef IMM_RANGE_CHECK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [2:0]           in_immg_op = 3'd0;
   logic [31:0]          in_imm = '0;
   logic [31:0]          in_base = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [31:0]          out_instr;
   logic                 out_err;
   logic [ERR_CNT_W-1:0] err_count;

   int checks = 0;
   int failures = 0;
   int exp_errs = 0;

   typedef struct {
      logic [31:0] instr;
      logic        err;
   } entry_t;

   immediate_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_immg_op(in_immg_op), .in_imm(in_imm), .in_base(in_base),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Reference: field table of (instr_lsb, width, imm_lsb) segments, fit via sign-extend round trip
   function automatic entry_t model(input int op, input logic [31:0] imm, input logic [31:0] base);
      entry_t e;
      int n, bits;
      int ilo[4], w[4], mlo[4];
      logic [31:0] mask;
      logic signed [31:0] t;
      bit fits;
      n = 0; bits = 0;
      case (op)
         0: begin n = 1; ilo[0] = 20; w[0] = 12; mlo[0] = 0; bits = 12; end
         1: begin n = 2; ilo[0] = 25; w[0] = 7; mlo[0] = 5; ilo[1] = 7; w[1] = 5; mlo[1] = 0; bits = 12; end
         2: begin n = 4; ilo[0] = 31; w[0] = 1; mlo[0] = 12; ilo[1] = 25; w[1] = 6; mlo[1] = 5;
                  ilo[2] = 8; w[2] = 4; mlo[2] = 1; ilo[3] = 7; w[3] = 1; mlo[3] = 11; bits = 13; end
         3: begin n = 1; ilo[0] = 12; w[0] = 20; mlo[0] = 12; end
         4: begin n = 4; ilo[0] = 31; w[0] = 1; mlo[0] = 20; ilo[1] = 21; w[1] = 10; mlo[1] = 1;
                  ilo[2] = 20; w[2] = 1; mlo[2] = 11; ilo[3] = 12; w[3] = 8; mlo[3] = 12; bits = 21; end
         default: n = 0;
      endcase
      e.instr = base;
      for (int k = 0; k < n; k++) begin
         mask = 32'((64'd1 << w[k]) - 1);
         e.instr = (e.instr & ~(mask << ilo[k])) | (((imm >> mlo[k]) & mask) << ilo[k]);
      end
      fits = 1'b1;
      if (op == 3) fits = (imm[11:0] == 12'd0);
      else if (op <= 4) begin
         t = imm << (32 - bits);
         t = t >>> (32 - bits);
         fits = (t == imm) && !((op == 2 || op == 4) && imm[0]);
      end
      e.err = (op > 4) || (RANGE_CHK && !fits);
      return e;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < ERR_MAX) ? v + 1 : ERR_MAX;
   endfunction

   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] imm, input logic [31:0] base);
      in_valid = v; in_immg_op = op; in_imm = imm; in_base = base;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks += 5;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (out_instr !== 32'd0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
      if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
      if (err_count !== '0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_i_type;
      out_ready = 1'b1;
      drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
      @(negedge clk);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL i_valid got=%b exp=1", out_valid); end
      if (out_instr !== 32'hFFF0_0013) begin failures++; $display("FAIL i_instr got=%h exp=fff00013", out_instr); end
      if (out_err !== 1'b0) begin failures++; $display("FAIL i_err got=%b exp=0", out_err); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL i_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_b_j;
      out_ready = 1'b1;
      drive(1'b1, 3'd2, 32'hFFFF_F000, 32'h0000_0063);
      @(negedge clk);
      checks += 2;
      if (out_instr !== 32'h8000_0063) begin failures++; $display("FAIL b_instr got=%h exp=80000063", out_instr); end
      if (out_err !== 1'b0) begin failures++; $display("FAIL b_err got=%b exp=0", out_err); end
      drive(1'b1, 3'd4, 32'h000F_FFFE, 32'h0000_006F);
      @(negedge clk);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL j_valid got=%b exp=1", out_valid); end
      if (out_instr !== 32'h7FFF_F06F) begin failures++; $display("FAIL j_instr got=%h exp=7ffff06f", out_instr); end
      if (out_err !== 1'b0) begin failures++; $display("FAIL j_err got=%b exp=0", out_err); end
      @(negedge clk);
   endtask

   task automatic test_range;
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 32'h0000_0800, 32'h0000_0013);
      @(negedge clk);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      if (RANGE_CHK) exp_errs = sat_inc(exp_errs);
      checks += 3;
      if (out_instr !== 32'h8000_0013) begin failures++; $display("FAIL range_instr got=%h exp=80000013", out_instr); end
      if (out_err !== RANGE_CHK) begin failures++; $display("FAIL range_err got=%b exp=%b", out_err, RANGE_CHK); end
      if (int'(err_count) != exp_errs) begin failures++; $display("FAIL range_count got=%0d exp=%0d", err_count, exp_errs); end
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      drive(1'b1, 3'd3, 32'h1234_5000, 32'h0000_0037);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
      drive(1'b1, 3'd3, 32'hABCD_E000, 32'h0000_00B7);
      @(negedge clk);
      drive(1'b1, 3'd3, 32'h0000_1000, 32'h0000_0017);
      checks += 2;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
      if (out_instr !== 32'h1234_5037) begin failures++; $display("FAIL bp_head0 got=%h exp=12345037", out_instr); end
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%b exp=0", in_ready); end
      if (out_instr !== 32'h1234_5037) begin failures++; $display("FAIL bp_hold got=%h exp=12345037", out_instr); end
      out_ready = 1'b1;
      @(negedge clk);
      checks += 2;
      if (out_instr !== 32'hABCD_E0B7) begin failures++; $display("FAIL bp_head1 got=%h exp=abcde0b7", out_instr); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
      @(negedge clk);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      checks += 2;
      if (out_instr !== 32'h0000_1017) begin failures++; $display("FAIL bp_head2 got=%h exp=00001017", out_instr); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid2 got=%b exp=1", out_valid); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      drive(1'b1, 3'd6, 32'd5, 32'h1111_1111);
      @(negedge clk);
      drive(1'b1, 3'd0, 32'd5, 32'h2222_2213);
      @(negedge clk);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL rm_full got=%b exp=0", in_ready); end
      #1 rst_n = 1'b0;
      #1;
      exp_errs = 0;
      checks += 4;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
      if (out_instr !== 32'd0) begin failures++; $display("FAIL rm_instr got=%h exp=0", out_instr); end
      if (err_count !== '0) begin failures++; $display("FAIL rm_count got=%0d exp=0", err_count); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
      @(negedge clk);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      checks += 2;
      if (out_instr !== 32'hFFF0_0013) begin failures++; $display("FAIL rm_after got=%h exp=fff00013", out_instr); end
      if (out_err !== 1'b0) begin failures++; $display("FAIL rm_after_err got=%b exp=0", out_err); end
      @(negedge clk);
   endtask

   task automatic test_random;
      entry_t q[$];
      entry_t e;
      logic [31:0] imm;
      logic [2:0] op;
      bit acc, pp;
      for (int cyc = 0; cyc < 300; cyc++) begin
         checks += 4;
         if (out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() != 0); end
         if (in_ready !== (q.size() != 2)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() != 2); end
         if (int'(err_count) != exp_errs) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, err_count, exp_errs); end
         if (q.size() != 0) begin
            if (out_instr !== q[0].instr || out_err !== q[0].err) begin
               failures++;
               $display("FAIL rnd_head cyc=%0d got=%h/%b exp=%h/%b", cyc, out_instr, out_err, q[0].instr, q[0].err);
            end
         end else if (out_instr !== 32'd0 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL rnd_empty cyc=%0d got=%h/%b exp=0/0", cyc, out_instr, out_err);
         end
         op = ($urandom_range(0, 15) == 0) ? 3'(5 + $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
         case ($urandom_range(0, 2))
            0: imm = $urandom;
            1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
            default: imm = $urandom & 32'hFFFF_F000;
         endcase
         drive(1'($urandom_range(0, 3) != 0), op, imm, $urandom);
         out_ready = 1'($urandom_range(0, 2) != 0);
         acc = in_valid && (q.size() != 2);
         pp  = out_ready && (q.size() != 0);
         e = model(int'(op), imm, in_base);
         @(posedge clk);
         if (pp) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            if (e.err) exp_errs = sat_inc(exp_errs);
         end
         @(negedge clk);
      end
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_saturation;
      logic [31:0] bases[$];
      out_ready = 1'b1;
      for (int i = 0; i <= 256; i++) begin
         if (i > 0) begin
            checks++;
            if (out_instr !== bases[i-1] || out_err !== 1'b1) begin
               failures++;
               $display("FAIL sat_word i=%0d got=%h/%b exp=%h/1", i, out_instr, out_err, bases[i-1]);
            end
         end
         if (i < 256) begin
            bases.push_back($urandom);
            drive(1'b1, 3'(5 + (i % 3)), $urandom, bases[i]);
            exp_errs = sat_inc(exp_errs);
         end else begin
            drive(1'b0, 3'd0, 32'd0, 32'd0);
         end
         @(negedge clk);
      end
      checks += 2;
      if (int'(err_count) != ERR_MAX) begin failures++; $display("FAIL sat_count got=%0d exp=%0d", err_count, ERR_MAX); end
      if (int'(err_count) != exp_errs) begin failures++; $display("FAIL sat_model got=%0d exp=%0d", err_count, exp_errs); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset;
      test_i_type;
      test_b_j;
      test_range;
      test_backpressure;
      test_reset_mid;
      test_random;
      test_saturation;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
